// File: rtl/rca_gb_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives the operation and the slave returns the registered result.
interface rca_gb_if #(
   parameter int unsigned G = 128
);
   logic         in_valid;
   logic [G-1:0] a;
   logic [G-1:0] b;
   logic         cin;
   logic [G-1:0] sum;
   logic         carry;
   logic         out_valid;

   modport master (
      output in_valid, a, b, cin,
      input  sum, carry, out_valid
   );

   modport slave (
      input  in_valid, a, b, cin,
      output sum, carry, out_valid
   );
endinterface

// File: rtl/rca_gb.sv
// G-bit ripple-carry adder built from a generate chain of full-adder cells.
// The result is registered once, giving one cycle of latency at full throughput.
module rca_gb #(
   parameter int unsigned G = 128
) (
   input logic     clk,
   input logic     rst,
   rca_gb_if.slave bus
);

   logic [G:0]   c;
   logic [G-1:0] s;

   logic [G-1:0] sum_q, sum_d;
   logic         carry_q, carry_d;
   logic         out_valid_q, out_valid_d;

   assign c[0] = bus.cin;

   // Pure ripple chain: each cell's carry-out feeds the next cell's carry-in.
   for (genvar i = 0; i < G; i++) begin : g_fa
      logic p;
      assign p        = bus.a[i] ^ bus.b[i];
      assign s[i]     = p ^ c[i];
      assign c[i + 1] = (bus.a[i] & bus.b[i]) | (c[i] & p);
   end

   always_comb begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      out_valid_d = 1'b0;
      if (bus.in_valid) begin
         sum_d       = s;
         carry_d     = c[G];
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.sum       = sum_q;
   assign bus.carry     = carry_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rca_gb.sv
// Directed bench for rca_gb at G=128 and an exhaustive sweep at G=4.
module tb_rca_gb;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rca_gb_if #(.G(128)) bus128 ();
   rca_gb_if #(.G(4))   bus4 ();

   rca_gb #(.G(128)) dut128 (.clk(clk), .rst(rst), .bus(bus128));
   rca_gb #(.G(4))   dut4   (.clk(clk), .rst(rst), .bus(bus4));

   task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk128(input string tag, input logic [128:0] exp_res, input logic exp_v);
      chk({tag, "_res"}, {bus128.carry, bus128.sum}, exp_res);
      chk({tag, "_vld"}, 129'(bus128.out_valid), 129'(exp_v));
   endtask

   logic [127:0] ones;
   logic [127:0] ra, rb;
   logic         rc;
   logic [4:0]   exp4;

   initial begin
      ones = '1;
      rst  = 1'b1;
      bus128.in_valid = 1'b1;
      bus128.a        = 128'd5;
      bus128.b        = 128'd0;
      bus128.cin      = 1'b0;
      bus4.in_valid   = 1'b1;
      bus4.a          = 4'd5;
      bus4.b          = 4'd0;
      bus4.cin        = 1'b0;

      // Reset held two cycles with a valid operation present.
      step();
      chk128("rst1", 129'd0, 1'b0);
      step();
      chk128("rst2", 129'd0, 1'b0);
      chk("rst_g4", 129'({bus4.carry, bus4.sum, bus4.out_valid}), 129'd0);

      rst = 1'b0;
      bus4.in_valid = 1'b0;

      // Small add.
      bus128.a = 128'd37; bus128.b = 128'd91; bus128.cin = 1'b1; bus128.in_valid = 1'b1;
      step();
      chk128("small", 129'd129, 1'b1);

      // Hold with changed operands.
      bus128.in_valid = 1'b0; bus128.a = 128'd1000; bus128.b = 128'd2000; bus128.cin = 1'b0;
      step();
      chk128("hold1", 129'd129, 1'b0);
      step();
      chk128("hold2", 129'd129, 1'b0);

      // Full ripple: all-ones + 0 + 1.
      bus128.in_valid = 1'b1; bus128.a = ones; bus128.b = '0; bus128.cin = 1'b1;
      step();
      chk128("ripple", {1'b1, 128'd0}, 1'b1);

      // Max case: all-ones + all-ones + 1.
      bus128.a = ones; bus128.b = ones; bus128.cin = 1'b1;
      step();
      chk128("max", {1'b1, ones}, 1'b1);

      // Carry into the top bit only, no carry out.
      bus128.a = {1'b0, ones[126:0]}; bus128.b = '0; bus128.cin = 1'b1;
      step();
      chk128("topbit", {1'b0, 1'b1, 127'd0}, 1'b1);

      // Back-to-back small random operations.
      for (int n = 0; n < 12; n++) begin
         ra = 128'($urandom_range(100));
         rb = 128'($urandom_range(100));
         rc = 1'($urandom_range(1));
         bus128.a = ra; bus128.b = rb; bus128.cin = rc;
         step();
         chk128("rand", {1'b0, ra} + {1'b0, rb} + 129'(rc), 1'b1);
      end
      bus128.in_valid = 1'b0;

      // Exhaustive G=4 sweep, one operation per cycle.
      bus4.in_valid = 1'b1;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               bus4.a = 4'(ia); bus4.b = 4'(ib); bus4.cin = 1'(ic);
               exp4 = 5'(ia + ib + ic);
               step();
               chk("exh4", 129'({bus4.carry, bus4.sum}), 129'(exp4));
               chk("exh4_vld", 129'(bus4.out_valid), 129'd1);
            end
         end
      end
      bus4.in_valid = 1'b0;
      step();
      chk("g4_idle_vld", 129'(bus4.out_valid), 129'd0);
      chk("g4_idle_hold", 129'({bus4.carry, bus4.sum}), 129'd31);

      // Reset has priority over a valid operation on the same edge.
      bus128.in_valid = 1'b1; bus128.a = 128'd10; bus128.b = 128'd20; bus128.cin = 1'b0;
      step();
      chk128("pre_rst", 129'd30, 1'b1);
      rst = 1'b1;
      bus128.a = 128'd7; bus128.b = 128'd8;
      step();
      chk128("rst_prio", 129'd0, 1'b0);
      rst = 1'b0;
      step();
      chk128("post_rst", 129'd15, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
